// File: rtl/icevga_pkg.sv
// icevga_pkg: shared definitions for the icevga codebase.
// Holds the line-buffer fill-state encoding and the default line-buffer
// geometry (words per visible line, per-bank word address width).
package icevga_pkg;

  // Fill-side state of the line-buffer ping-pong scheduler.
  typedef enum logic {
    FILL  = 1'b0,
    READY = 1'b1
  } fill_state_e;

  localparam int LINEBUF_WORDS_PER_LINE = 50;
  localparam int LINEBUF_ADDR_W         = 8;

endpackage

// File: rtl/linebuf_bank_ctl_if.sv
// linebuf_bank_ctl_if: command-processor write handshake into the
// line-buffer bank controller.
//   wr_req  : command processor offers a word
//   wr_data : 16-bit pixel word
//   wr_ack  : word accepted this cycle (combinational from the controller)
// master = command processor, slave = linebuf_bank_ctl.
interface linebuf_bank_ctl_if;
  logic        wr_req;
  logic [15:0] wr_data;
  logic        wr_ack;

  modport master (output wr_req, output wr_data, input wr_ack);
  modport slave  (input wr_req, input wr_data, output wr_ack);
endinterface

// File: rtl/linebuf_bank_ctl_sat_counter.sv
// sat_counter: 8-bit counter that increments on inc and holds at 255.
//   clk   : clock
//   nrst  : synchronous, active-high clear
//   inc   : increment request
//   count : current count
module sat_counter (
  input  logic       clk,
  input  logic       nrst,
  input  logic       inc,
  output logic [7:0] count
);

  logic [7:0] count_r;

  // Saturating count register.
  always_ff @(posedge clk) begin
    if (nrst) begin
      count_r <= 8'd0;
    end else if (inc && (count_r != 8'hFF)) begin
      count_r <= count_r + 8'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;

endmodule

// File: rtl/linebuf_bank_ctl.sv
// linebuf_bank_ctl: ping-pong scheduler for the 512x16 line-buffer RAM,
// split into two banks of 2**ADDR_W words. The pixel generator reads the
// display bank while the command processor fills the other one; banks swap
// at line_end only once the fill bank is complete, otherwise an underrun is
// flagged and the old bank is shown again.
// Ports:
//   clk, nrst          : pixel clock, synchronous active-high reset
//   line_end           : pulse at last visible pixel of a line
//   flush              : pulse, discard partial fill and restart at word 0
//   wr_bus (slave)     : wr_req / wr_data / wr_ack write handshake
//   pix_raddr          : pixel-generator word address
//   ram_raddr          : {disp_bank, pix_raddr} to the RAM read port
//   ram_waddr/wdata    : registered RAM write address / data
//   ram_wclke          : registered RAM write enable
//   disp_bank          : bank being displayed
//   fill_ready         : fill bank complete, waiting for swap
//   underrun           : pulse, line_end seen while fill incomplete
//   underrun_cnt       : saturating underrun count (only with
//                        LINEBUF_UNDERRUN_CNT_EN defined)
module linebuf_bank_ctl
  import icevga_pkg::*;
#(
  parameter int WORDS_PER_LINE = LINEBUF_WORDS_PER_LINE,
  parameter int ADDR_W         = LINEBUF_ADDR_W
) (
  input  logic                clk,
  input  logic                nrst,
  input  logic                line_end,
  input  logic                flush,
  linebuf_bank_ctl_if.slave   wr_bus,
  input  logic [ADDR_W-1:0]   pix_raddr,
  output logic [ADDR_W:0]     ram_raddr,
  output logic [ADDR_W:0]     ram_waddr,
  output logic [15:0]         ram_wdata,
  output logic                ram_wclke,
  output logic                disp_bank,
  output logic                fill_ready,
  output logic                underrun
`ifdef LINEBUF_UNDERRUN_CNT_EN
  ,
  output logic [7:0]          underrun_cnt
`endif
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WORDS_PER_LINE - 1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = ADDR_W'(0);

  fill_state_e       state_r;
  fill_state_e       state_nxt_s;
  logic [ADDR_W-1:0] fill_addr_r;
  logic [ADDR_W-1:0] fill_addr_nxt_s;
  logic              disp_bank_r;
  logic              disp_bank_nxt_s;
  logic              wr_ack_s;
  logic              underrun_nxt_s;

  logic [ADDR_W:0]   ram_waddr_r;
  logic [15:0]       ram_wdata_r;
  logic              ram_wclke_r;
  logic              fill_ready_r;
  logic              underrun_r;

  // Next-state, fill address, bank swap and handshake decode.
  always_comb begin
    state_nxt_s     = state_r;
    fill_addr_nxt_s = fill_addr_r;
    disp_bank_nxt_s = disp_bank_r;
    wr_ack_s        = 1'b0;
    underrun_nxt_s  = 1'b0;

    case (state_r)
      FILL: begin
        wr_ack_s       = wr_bus.wr_req & ~nrst & ~flush;
        // The state before the edge decides: a final word landing together
        // with line_end is still an underrun.
        underrun_nxt_s = line_end & ~flush;
        if (wr_ack_s) begin
          if (fill_addr_r == LAST_ADDR) begin
            state_nxt_s = READY;
          end else begin
            fill_addr_nxt_s = fill_addr_r + ADDR_ONE;
          end
        end else begin
          state_nxt_s = FILL;
        end
      end
      READY: begin
        if (line_end && !flush) begin
          disp_bank_nxt_s = ~disp_bank_r;
          fill_addr_nxt_s = ADDR_ZERO;
          state_nxt_s     = FILL;
        end else begin
          state_nxt_s = READY;
        end
      end
      default: begin
        state_nxt_s     = FILL;
        fill_addr_nxt_s = ADDR_ZERO;
      end
    endcase

    // Flush beats everything else and never swaps the display bank.
    if (flush) begin
      state_nxt_s     = FILL;
      fill_addr_nxt_s = ADDR_ZERO;
    end else begin
      underrun_nxt_s = underrun_nxt_s;
    end
  end

  // FSM state, fill address and display-bank registers.
  always_ff @(posedge clk) begin
    if (nrst) begin
      state_r     <= FILL;
      fill_addr_r <= ADDR_ZERO;
      disp_bank_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      fill_addr_r <= fill_addr_nxt_s;
      disp_bank_r <= disp_bank_nxt_s;
    end
  end

  // Registered RAM write port and status flags. The bank bit is captured at
  // accept time, so a swap one cycle later cannot redirect the write.
  always_ff @(posedge clk) begin
    if (nrst) begin
      ram_waddr_r  <= '0;
      ram_wdata_r  <= 16'h0000;
      ram_wclke_r  <= 1'b0;
      fill_ready_r <= 1'b0;
      underrun_r   <= 1'b0;
    end else begin
      ram_wclke_r  <= wr_ack_s;
      fill_ready_r <= (state_nxt_s == READY);
      underrun_r   <= underrun_nxt_s;
      if (wr_ack_s) begin
        ram_waddr_r <= {~disp_bank_r, fill_addr_r};
        ram_wdata_r <= wr_bus.wr_data;
      end else begin
        ram_waddr_r <= ram_waddr_r;
        ram_wdata_r <= ram_wdata_r;
      end
    end
  end

  assign wr_bus.wr_ack = wr_ack_s;
  assign ram_raddr     = {disp_bank_r, pix_raddr};
  assign ram_waddr     = ram_waddr_r;
  assign ram_wdata     = ram_wdata_r;
  assign ram_wclke     = ram_wclke_r;
  assign disp_bank     = disp_bank_r;
  assign fill_ready    = fill_ready_r;
  assign underrun      = underrun_r;

`ifdef LINEBUF_UNDERRUN_CNT_EN
  sat_counter u_underrun_cnt (
    .clk   (clk),
    .nrst  (nrst),
    .inc   (underrun_r),
    .count (underrun_cnt)
  );
`endif

endmodule

// File: tb/tb_linebuf_bank_ctl.sv
// tb_linebuf_bank_ctl: randomized and directed stimulus for linebuf_bank_ctl,
// checked against a word-count model of the ping-pong line buffer.
module tb_linebuf_bank_ctl;

  localparam int WPL = 50;

  logic        clk;
  logic        nrst;
  logic        line_end;
  logic        flush;
  logic [7:0]  pix_raddr;
  logic [8:0]  ram_raddr;
  logic [8:0]  ram_waddr;
  logic [15:0] ram_wdata;
  logic        ram_wclke;
  logic        disp_bank;
  logic        fill_ready;
  logic        underrun;
`ifdef LINEBUF_UNDERRUN_CNT_EN
  logic [7:0]  underrun_cnt;
`endif

  linebuf_bank_ctl_if bus ();

  linebuf_bank_ctl dut (
    .clk        (clk),
    .nrst       (nrst),
    .line_end   (line_end),
    .flush      (flush),
    .wr_bus     (bus.slave),
    .pix_raddr  (pix_raddr),
    .ram_raddr  (ram_raddr),
    .ram_waddr  (ram_waddr),
    .ram_wdata  (ram_wdata),
    .ram_wclke  (ram_wclke),
    .disp_bank  (disp_bank),
    .fill_ready (fill_ready),
    .underrun   (underrun)
`ifdef LINEBUF_UNDERRUN_CNT_EN
    ,
    .underrun_cnt (underrun_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_compared;
  int n_mismatched;
  int acks;

  // Model: number of words held in the fill bank (WPL means full), which bank
  // is displayed, and the expected registered outputs.
  int          m_filled;
  logic        m_disp;
  logic        m_wclke;
  logic [8:0]  m_waddr;
  logic [15:0] m_wdata;
  logic        m_under;
  int          m_ucnt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatched++;
      $display("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic step(input logic rst, input logic le, input logic fl,
                      input logic req, input logic [15:0] data);
    logic exp_ack;
    logic prev_under;
    @(negedge clk);
    nrst        = rst;
    line_end    = le;
    flush       = fl;
    bus.wr_req  = req;
    bus.wr_data = data;
    pix_raddr   = 8'($urandom_range(0, 255));
    #1;
    exp_ack = !rst && !fl && req && (m_filled < WPL);
    check_eq("wr_ack", {31'd0, bus.wr_ack}, {31'd0, exp_ack});
    check_eq("ram_raddr", {23'd0, ram_raddr}, {23'd0, m_disp, pix_raddr});
    if (bus.wr_ack) acks++;
    prev_under = m_under;
    if (rst) begin
      m_filled = 0;
      m_disp   = 1'b0;
      m_wclke  = 1'b0;
      m_waddr  = 9'h000;
      m_wdata  = 16'h0000;
      m_under  = 1'b0;
      m_ucnt   = 0;
    end else begin
      m_wclke = exp_ack;
      if (exp_ack) begin
        m_waddr = {~m_disp, 8'(m_filled)};
        m_wdata = data;
      end
      m_under = le && !fl && (m_filled < WPL);
      if (fl) begin
        m_filled = 0;
      end else if (le && (m_filled == WPL)) begin
        m_disp   = ~m_disp;
        m_filled = 0;
      end else if (exp_ack) begin
        m_filled++;
      end
      if (prev_under && (m_ucnt < 255)) m_ucnt++;
    end
    @(posedge clk);
    #1;
    check_eq("ram_wclke", {31'd0, ram_wclke}, {31'd0, m_wclke});
    check_eq("ram_waddr", {23'd0, ram_waddr}, {23'd0, m_waddr});
    check_eq("ram_wdata", {16'd0, ram_wdata}, {16'd0, m_wdata});
    check_eq("underrun", {31'd0, underrun}, {31'd0, m_under});
    check_eq("fill_ready", {31'd0, fill_ready}, {31'd0, (m_filled == WPL)});
    check_eq("disp_bank", {31'd0, disp_bank}, {31'd0, m_disp});
`ifdef LINEBUF_UNDERRUN_CNT_EN
    check_eq("underrun_cnt", {24'd0, underrun_cnt}, 32'(m_ucnt));
`endif
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'hFFFF);
  endtask

  task automatic push_words(input int first, input int n);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b0, 1'b0, 1'b1, 16'(first + i));
    end
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    acks         = 0;
    m_filled     = 0;
    m_disp       = 1'b0;
    m_wclke      = 1'b0;
    m_waddr      = 9'h000;
    m_wdata      = 16'h0000;
    m_under      = 1'b0;
    m_ucnt       = 0;
    nrst         = 1'b1;
    line_end     = 1'b0;
    flush        = 1'b0;
    bus.wr_req   = 1'b0;
    bus.wr_data  = 16'h0000;
    pix_raddr    = 8'h00;

    // Reset state.
    do_reset();

    // Basic fill and swap.
    acks = 0;
    push_words(0, WPL);
    check_eq("basic_acks", 32'(acks), 32'd50);
    check_eq("basic_ready", {31'd0, fill_ready}, 32'd1);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    check_eq("basic_swap", {31'd0, disp_bank}, 32'd1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);

    // Underrun, then completion and swap.
    do_reset();
    push_words(0, 20);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    check_eq("ur_pulse", {31'd0, underrun}, 32'd1);
    check_eq("ur_noswap", {31'd0, disp_bank}, 32'd0);
    push_words(20, 30);
    check_eq("ur_last_addr", {23'd0, ram_waddr}, 32'h131);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    check_eq("ur_swap", {31'd0, disp_bank}, 32'd1);

    // Final word together with line_end.
    do_reset();
    push_words(0, WPL - 1);
    step(1'b0, 1'b1, 1'b0, 1'b1, 16'd49);
    check_eq("sim_under", {31'd0, underrun}, 32'd1);
    check_eq("sim_noswap", {31'd0, disp_bank}, 32'd0);
    check_eq("sim_ready", {31'd0, fill_ready}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    check_eq("sim_swap", {31'd0, disp_bank}, 32'd1);

    // Flush with line_end: flush wins.
    push_words(16'h0A00, 10);
    step(1'b0, 1'b1, 1'b1, 1'b1, 16'hDEAD);
    check_eq("fl_nounder", {31'd0, underrun}, 32'd0);
    check_eq("fl_disp", {31'd0, disp_bank}, 32'd1);
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'hBEEF);
    check_eq("fl_addr", {23'd0, ram_waddr}, 32'h000);

    // Backpressure in READY, then reset mid-fill.
    push_words(16'h0B01, WPL - 1);
    acks = 0;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 16'h5555);
    check_eq("bp_acks", 32'(acks), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    push_words(16'h0C00, 7);
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'h1234);
    check_eq("rst_disp", {31'd0, disp_bank}, 32'd0);
    check_eq("rst_wclke", {31'd0, ram_wclke}, 32'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 999) < 3),
           ($urandom_range(0, 99) < 2),
           ($urandom_range(0, 99) < 1),
           ($urandom_range(0, 99) < 70),
           16'($urandom));
    end

`ifdef LINEBUF_UNDERRUN_CNT_EN
    // Saturation of the underrun counter.
    do_reset();
    for (int i = 0; i < 260; i++) step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    check_eq("cnt_sat", {24'd0, underrun_cnt}, 32'd255);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
